usb_command_sequencer: RTL and testbench

// - Consumes the 16-bit command words that the USB slave-FIFO read path pulls from EP2
//   (ControlWord qualified by the Ctr_rd_en strobe).
// - Decodes acquisition start/stop, timed runs and configuration-register writes.
// - Drives Acq_Start_Stop, which gates the EP6 upload path, plus a flat config register bank.
// - Sits in the IFCLK domain between the slave-FIFO controller and the DIF readout/config logic.

---
 rtl/usb_command_sequencer.sv | 170 +++++++++++++++++
 tb/tb_usb_command_sequencer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_command_sequencer.sv
// EP2 command-word decoder: acquisition start/stop, timed runs and a flat config register bank.
// Two FSMs share one decode stage: one assembles header/payload pairs, one tracks acquisition.
module usb_command_sequencer #(
    parameter int NUM_REGS = 8,
    parameter int PRESCALE = 48000,
    parameter int TIMEOUT  = 4096
) (
    input  logic                    IFCLK,
    input  logic                    reset_n,
    input  logic                    Ctr_rd_en,
    input  logic [15:0]             ControlWord,
    output logic                    Acq_Start_Stop,
    output logic                    acq_busy,
    output logic [NUM_REGS*16-1:0]  cfg_data,
    output logic                    cfg_wr_strobe,
    output logic [7:0]              cfg_wr_addr,
    output logic [7:0]              cmd_err_cnt
);

    localparam int PW = $clog2(PRESCALE);
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);
    localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);

    localparam logic [15:0] CMD_START = 16'hA0F0;
    localparam logic [15:0] CMD_STOP  = 16'hA0F1;
    localparam logic [15:0] CMD_TIMED = 16'hC000;

    typedef enum logic [1:0] {CMD_IDLE, CMD_WAIT_REG, CMD_WAIT_CNT} cmd_state_t;
    typedef enum logic [1:0] {ACQ_OFF, ACQ_ON, ACQ_TIMED} acq_state_t;

    cmd_state_t     cmd_state;
    acq_state_t     acq_state;
    logic [7:0]     reg_addr;
    logic [TW-1:0]  tmo_cnt;
    logic [PW-1:0]  presc_cnt;
    logic [15:0]    remaining;

    logic is_reg_hdr, is_timed_hdr, addr_ok, tmo_hit;
    logic go_on, go_timed, go_stop, do_write, err_evt;

    assign is_reg_hdr   = (ControlWord[15:8] == 8'hB0);
    assign is_timed_hdr = (ControlWord == CMD_TIMED);
    assign addr_ok      = ({24'd0, reg_addr} < 32'(NUM_REGS));
    assign tmo_hit      = (tmo_cnt == TMO_LAST);

    // Every command error is decided against the acquisition state before this edge.
    always_comb begin
        go_on    = 1'b0;
        go_timed = 1'b0;
        go_stop  = 1'b0;
        do_write = 1'b0;
        err_evt  = 1'b0;
        case (cmd_state)
            CMD_IDLE: begin
                if (Ctr_rd_en) begin
                    if (ControlWord == CMD_START) begin
                        if (acq_state == ACQ_OFF) go_on = 1'b1;
                        else                      err_evt = 1'b1;
                    end else if (ControlWord == CMD_STOP) begin
                        go_stop = 1'b1;
                    end else if (!(is_reg_hdr || is_timed_hdr)) begin
                        err_evt = 1'b1;
                    end
                end
            end
            CMD_WAIT_REG: begin
                if (Ctr_rd_en) begin
                    if (addr_ok) do_write = 1'b1;
                    else         err_evt  = 1'b1;
                end else if (tmo_hit) begin
                    err_evt = 1'b1;
                end
            end
            CMD_WAIT_CNT: begin
                if (Ctr_rd_en) begin
                    if (acq_state != ACQ_OFF)       err_evt  = 1'b1;
                    else if (ControlWord == 16'h0)  go_on    = 1'b1;
                    else                            go_timed = 1'b1;
                end else if (tmo_hit) begin
                    err_evt = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge IFCLK or negedge reset_n) begin
        if (!reset_n) begin
            cmd_state     <= CMD_IDLE;
            reg_addr      <= 8'd0;
            tmo_cnt       <= '0;
            cfg_data      <= '0;
            cfg_wr_strobe <= 1'b0;
            cfg_wr_addr   <= 8'd0;
            cmd_err_cnt   <= 8'd0;
        end else begin
            cfg_wr_strobe <= do_write;
            if (do_write) begin
                cfg_wr_addr <= reg_addr;
                for (int r = 0; r < NUM_REGS; r++) begin
                    if (reg_addr == 8'(r)) cfg_data[16*r +: 16] <= ControlWord;
                end
            end
            if (err_evt && cmd_err_cnt != 8'hFF) cmd_err_cnt <= cmd_err_cnt + 8'd1;
            case (cmd_state)
                CMD_IDLE: begin
                    if (Ctr_rd_en && is_reg_hdr) begin
                        cmd_state <= CMD_WAIT_REG;
                        reg_addr  <= ControlWord[7:0];
                        tmo_cnt   <= '0;
                    end else if (Ctr_rd_en && is_timed_hdr) begin
                        cmd_state <= CMD_WAIT_CNT;
                        tmo_cnt   <= '0;
                    end
                end
                CMD_WAIT_REG, CMD_WAIT_CNT: begin
                    if (Ctr_rd_en || tmo_hit) cmd_state <= CMD_IDLE;
                    else                      tmo_cnt   <= tmo_cnt + 1'b1;
                end
                default: cmd_state <= CMD_IDLE;
            endcase
        end
    end

    // A stop overrides everything, including the final tick of a timed run.
    always_ff @(posedge IFCLK or negedge reset_n) begin
        if (!reset_n) begin
            acq_state      <= ACQ_OFF;
            Acq_Start_Stop <= 1'b0;
            acq_busy       <= 1'b0;
            presc_cnt      <= '0;
            remaining      <= 16'd0;
        end else if (go_stop) begin
            acq_state      <= ACQ_OFF;
            Acq_Start_Stop <= 1'b0;
            acq_busy       <= 1'b0;
        end else begin
            case (acq_state)
                ACQ_OFF: begin
                    if (go_on) begin
                        acq_state      <= ACQ_ON;
                        Acq_Start_Stop <= 1'b1;
                    end else if (go_timed) begin
                        acq_state      <= ACQ_TIMED;
                        Acq_Start_Stop <= 1'b1;
                        acq_busy       <= 1'b1;
                        remaining      <= ControlWord;
                        presc_cnt      <= '0;
                    end
                end
                ACQ_TIMED: begin
                    if (presc_cnt == PRESC_LAST) begin
                        presc_cnt <= '0;
                        remaining <= remaining - 16'd1;
                        if (remaining == 16'd1) begin
                            acq_state      <= ACQ_OFF;
                            Acq_Start_Stop <= 1'b0;
                            acq_busy       <= 1'b0;
                        end
                    end else begin
                        presc_cnt <= presc_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_usb_command_sequencer.sv
// Randomized and directed bench for usb_command_sequencer against a cycle-level command model.
module tb_usb_command_sequencer;

    localparam int NREGS = 8;
    localparam int PRE   = 4;
    localparam int TMO   = 16;

    logic                 IFCLK = 1'b0;
    logic                 reset_n;
    logic                 Ctr_rd_en;
    logic [15:0]          ControlWord;
    logic                 Acq_Start_Stop;
    logic                 acq_busy;
    logic [NREGS*16-1:0]  cfg_data;
    logic                 cfg_wr_strobe;
    logic [7:0]           cfg_wr_addr;
    logic [7:0]           cmd_err_cnt;

    usb_command_sequencer #(.NUM_REGS(NREGS), .PRESCALE(PRE), .TIMEOUT(TMO)) dut (
        .IFCLK(IFCLK), .reset_n(reset_n), .Ctr_rd_en(Ctr_rd_en), .ControlWord(ControlWord),
        .Acq_Start_Stop(Acq_Start_Stop), .acq_busy(acq_busy), .cfg_data(cfg_data),
        .cfg_wr_strobe(cfg_wr_strobe), .cfg_wr_addr(cfg_wr_addr), .cmd_err_cnt(cmd_err_cnt)
    );

    always #5 IFCLK = ~IFCLK;

    int total = 0;
    int bad   = 0;

    // Model: pending command kind (0 none, 1 reg write, 2 timed count) with its age in cycles,
    // acquisition mode (0 off, 1 on, 2 timed) with the number of high cycles still owed.
    int          m_pend, m_age, m_acq, m_left, m_err;
    logic [7:0]  m_pend_addr, m_waddr;
    logic        m_strobe;
    logic [15:0] m_cfg [NREGS];

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] modelCfg();
        logic [127:0] v = '0;
        for (int r = 0; r < NREGS; r++) v[16*r +: 16] = m_cfg[r];
        return v;
    endfunction

    task automatic modelReset();
        m_pend = 0; m_age = 0; m_acq = 0; m_left = 0; m_err = 0;
        m_pend_addr = 8'd0; m_waddr = 8'd0; m_strobe = 1'b0;
        for (int r = 0; r < NREGS; r++) m_cfg[r] = 16'd0;
    endtask

    task automatic modelStep(input logic en, input logic [15:0] w);
        int  err = 0;
        int  pre_acq = m_acq;
        bit  want_on = 0, want_timed = 0, want_stop = 0;
        m_strobe = 1'b0;
        if (m_pend != 0) begin
            m_age++;
            if (en) begin
                if (m_pend == 1) begin
                    if (int'(m_pend_addr) < NREGS) begin
                        m_cfg[m_pend_addr] = w;
                        m_strobe = 1'b1;
                        m_waddr = m_pend_addr;
                    end else err = 1;
                end else begin
                    if (pre_acq != 0) err = 1;
                    else if (w == 16'h0) want_on = 1;
                    else want_timed = 1;
                end
                m_pend = 0;
            end else if (m_age == TMO) begin
                err = 1;
                m_pend = 0;
            end
        end else if (en) begin
            if (w == 16'hA0F0) begin
                if (pre_acq != 0) err = 1; else want_on = 1;
            end else if (w == 16'hA0F1) want_stop = 1;
            else if (w[15:8] == 8'hB0) begin
                m_pend = 1; m_age = 0; m_pend_addr = w[7:0];
            end else if (w == 16'hC000) begin
                m_pend = 2; m_age = 0;
            end else err = 1;
        end
        if (want_stop) m_acq = 0;
        else if (m_acq == 2) begin
            m_left--;
            if (m_left == 0) m_acq = 0;
        end else if (m_acq == 0) begin
            if (want_on) m_acq = 1;
            else if (want_timed) begin
                m_acq = 2;
                m_left = int'(w) * PRE;
            end
        end
        if (err != 0 && m_err < 255) m_err++;
    endtask

    task automatic compareAll();
        checkOutput("acq",    Acq_Start_Stop, (m_acq != 0));
        checkOutput("busy",   acq_busy,       (m_acq == 2));
        checkOutput("cfg",    cfg_data,       modelCfg());
        checkOutput("strobe", cfg_wr_strobe,  m_strobe);
        checkOutput("waddr",  cfg_wr_addr,    m_waddr);
        checkOutput("err",    cmd_err_cnt,    m_err[7:0]);
    endtask

    task automatic applyStimulus(input logic en, input logic [15:0] w);
        @(negedge IFCLK);
        Ctr_rd_en   = en;
        ControlWord = en ? w : 16'($urandom);
        @(posedge IFCLK);
        modelStep(en, w);
        #1;
        compareAll();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 16'h0);
    endtask

    task automatic asyncReset();
        @(negedge IFCLK);
        Ctr_rd_en = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        modelReset();
        compareAll();
        @(negedge IFCLK);
        @(negedge IFCLK);
        reset_n = 1'b1;
    endtask

    int hi, bhi;

    initial begin
        reset_n = 1'b0;
        Ctr_rd_en = 1'b0;
        ControlWord = 16'h0;
        modelReset();
        @(posedge IFCLK);
        #1;
        compareAll();
        checkOutput("reset_err", cmd_err_cnt, 8'h00);
        @(negedge IFCLK);
        reset_n = 1'b1;

        // T1 start / stop
        applyStimulus(1'b1, 16'hA0F0);
        checkOutput("t1_start", Acq_Start_Stop, 1'b1);
        applyStimulus(1'b1, 16'hA0F1);
        checkOutput("t1_stop", Acq_Start_Stop, 1'b0);
        checkOutput("t1_err", cmd_err_cnt, 8'h00);

        // T2 register writes, in range and out of range
        applyStimulus(1'b1, 16'hB003);
        applyStimulus(1'b1, 16'h1234);
        checkOutput("t2_data", cfg_data[63:48], 16'h1234);
        checkOutput("t2_strobe", cfg_wr_strobe, 1'b1);
        checkOutput("t2_addr", cfg_wr_addr, 8'd3);
        idle(1);
        checkOutput("t2_strobe_off", cfg_wr_strobe, 1'b0);
        applyStimulus(1'b1, 16'hB009);
        applyStimulus(1'b1, 16'hBEEF);
        checkOutput("t2_bad_strobe", cfg_wr_strobe, 1'b0);
        checkOutput("t2_bad_err", cmd_err_cnt, 8'd1);

        // T3 timed run of 3 ticks, then an aborted one
        applyStimulus(1'b1, 16'hC000);
        hi = 0; bhi = 0;
        applyStimulus(1'b1, 16'h0003);
        if (Acq_Start_Stop) hi++;
        if (acq_busy) bhi++;
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b0, 16'h0);
            if (Acq_Start_Stop) hi++;
            if (acq_busy) bhi++;
        end
        checkOutput("t3_high", hi, 12);
        checkOutput("t3_busy", bhi, 12);
        applyStimulus(1'b1, 16'hC000);
        applyStimulus(1'b1, 16'h0003);
        idle(5);
        applyStimulus(1'b1, 16'hA0F1);
        checkOutput("t3_abort_acq", Acq_Start_Stop, 1'b0);
        checkOutput("t3_abort_busy", acq_busy, 1'b0);

        // T4 timeout, then the late word is a header; payload on the last allowed cycle wins
        applyStimulus(1'b1, 16'hB001);
        idle(16);
        checkOutput("t4_tmo_err", cmd_err_cnt, 8'd2);
        applyStimulus(1'b1, 16'h5555);
        checkOutput("t4_late_err", cmd_err_cnt, 8'd3);
        checkOutput("t4_late_strobe", cfg_wr_strobe, 1'b0);
        applyStimulus(1'b1, 16'hB002);
        idle(15);
        applyStimulus(1'b1, 16'hABCD);
        checkOutput("t4_edge_strobe", cfg_wr_strobe, 1'b1);
        checkOutput("t4_edge_data", cfg_data[47:32], 16'hABCD);
        checkOutput("t4_edge_err", cmd_err_cnt, 8'd3);

        // T5 error counting and saturation
        asyncReset();
        applyStimulus(1'b1, 16'h0000);
        applyStimulus(1'b1, 16'hFFFF);
        applyStimulus(1'b1, 16'hA0F0);
        applyStimulus(1'b1, 16'hA0F0);
        checkOutput("t5_err", cmd_err_cnt, 8'd3);
        checkOutput("t5_acq", Acq_Start_Stop, 1'b1);
        applyStimulus(1'b1, 16'hA0F1);
        for (int i = 0; i < 300; i++) applyStimulus(1'b1, 16'h1111);
        checkOutput("t5_sat", cmd_err_cnt, 8'hFF);

        // T6 reset mid-run and mid-command
        asyncReset();
        applyStimulus(1'b1, 16'hC000);
        applyStimulus(1'b1, 16'h0003);
        idle(3);
        asyncReset();
        checkOutput("t6_run_acq", Acq_Start_Stop, 1'b0);
        applyStimulus(1'b1, 16'hB001);
        asyncReset();
        applyStimulus(1'b1, 16'hA0F0);
        checkOutput("t6_restart", Acq_Start_Stop, 1'b1);
        checkOutput("t6_err", cmd_err_cnt, 8'd0);

        // Randomized traffic
        asyncReset();
        for (int n = 0; n < 1500; n++) begin
            int r = int'($urandom_range(0, 99));
            if (r < 35) idle(1);
            else if (r < 45) applyStimulus(1'b1, 16'hA0F0);
            else if (r < 55) applyStimulus(1'b1, 16'hA0F1);
            else if (r < 70) applyStimulus(1'b1, {8'hB0, 8'($urandom_range(0, 11))});
            else if (r < 78) begin
                applyStimulus(1'b1, 16'hC000);
                idle(int'($urandom_range(0, 3)));
                applyStimulus(1'b1, 16'($urandom_range(0, 4)));
            end else if (r < 93) applyStimulus(1'b1, 16'($urandom));
            else idle(int'($urandom_range(14, 18)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
